// File: rtl/spi_pkg.sv
// Shared types and helpers for the oversampled SPI target.
// Mode constants are packed as {CPOL, CPHA}.
package spi_pkg;

   typedef enum logic [1:0] {
      WAIT_DESEL,
      IDLE,
      ACTIVE
   } spi_state_e;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Bit position that is presented on miso first and filled last on receive.
   function automatic int head_idx(input int width, input bit msb_first);
      return msb_first ? width - 1 : 0;
   endfunction

endpackage

// File: rtl/spi_slave_mode_sync_edge.sv
// Brings spi_clk, spi_cs_n and mosi into the clk domain and flags
// leading/trailing spi_clk transitions relative to the idle level CPOL.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit CPOL        = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic spi_clk_i,
   input  logic spi_cs_n_i,
   input  logic mosi_i,
   output logic cs_n_o,
   output logic mosi_o,
   output logic lead_o,
   output logic trail_o
);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   sclk_s;

   // cs_n resets to "selected" so a frame already in flight at reset is
   // skipped until the master genuinely deselects.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_sync_q <= {SYNC_STAGES{CPOL}};
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= CPOL;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign cs_n_o  = cs_sync_q[SYNC_STAGES-1];
   assign mosi_o  = mosi_sync_q[SYNC_STAGES-1];
   assign lead_o  = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
   assign trail_o = (sclk_prev_q != CPOL) && (sclk_s == CPOL);

endmodule

// File: rtl/spi_slave_mode.sv
// SPI target for all four CPOL/CPHA modes with a one-word TX buffer
// and single-cycle RX strobes, oversampled in the clk domain.
module spi_slave_mode
   import spi_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter bit               CPOL        = 1'b0,
   parameter bit               CPHA        = 1'b0,
   parameter bit               MSB_FIRST   = 1'b1,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_FILL   = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             spi_clk_i,
   input  logic             spi_cs_n_i,
   input  logic             mosi_i,
   output logic             miso_o,
   output logic             miso_oe_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   output logic             busy_o,
   output logic             underrun_o
);

   localparam int         CW             = $clog2(WIDTH);
   localparam int         HEAD           = head_idx(WIDTH, MSB_FIRST);
   localparam logic [1:0] MODE           = {CPOL, CPHA};
   localparam bit         SAMPLE_ON_LEAD = (MODE == MODE0) || (MODE == MODE2);

   spi_state_e       state_q;
   logic [WIDTH-1:0] tx_buf_q, tx_shift_q, rx_shift_q, rx_data_q;
   logic [WIDTH-1:0] tx_shift_d, rx_shift_d, tx_adv, load_word;
   logic [CW-1:0]    cnt_q;
   logic             tx_full_q, rx_valid_q, busy_q, done_q, underrun_q;
   logic             miso_q, miso_oe_q;
   logic             cs_n_s, mosi_s, lead, trail;
   logic             sample_edge, shift_edge, last_bit, tx_accept, load_evt;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .CPOL        (CPOL)
   ) u_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .spi_clk_i  (spi_clk_i),
      .spi_cs_n_i (spi_cs_n_i),
      .mosi_i     (mosi_i),
      .cs_n_o     (cs_n_s),
      .mosi_o     (mosi_s),
      .lead_o     (lead),
      .trail_o    (trail)
   );

   assign sample_edge = SAMPLE_ON_LEAD ? lead : trail;
   assign shift_edge  = SAMPLE_ON_LEAD ? trail : lead;
   assign last_bit    = (cnt_q == CW'(WIDTH - 1));
   assign tx_accept   = tx_valid_i && !tx_full_q;

   // CPHA=0 loads at select and on the shift edge after a finished word;
   // CPHA=1 loads on the first leading edge of every word.
   assign load_evt = !cs_n_s &&
                     (((state_q == IDLE) && !CPHA) ||
                      ((state_q == ACTIVE) && shift_edge &&
                       (CPHA ? (cnt_q == '0) : done_q)));

   always_comb begin
      if (MSB_FIRST) begin
         tx_adv     = {tx_shift_q[WIDTH-2:0], 1'b0};
         rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      end else begin
         tx_adv     = {1'b0, tx_shift_q[WIDTH-1:1]};
         rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
      end
      load_word  = tx_full_q ? tx_buf_q : IDLE_FILL;
      tx_shift_d = load_evt ? load_word : tx_adv;
   end

   // Buffer fill is applied after the load so a same-cycle fill survives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= WAIT_DESEL;
         tx_buf_q   <= '0;
         tx_full_q  <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         case (state_q)
            WAIT_DESEL: begin
               if (cs_n_s) state_q <= IDLE;
            end
            IDLE: begin
               if (!cs_n_s) begin
                  state_q   <= ACTIVE;
                  miso_oe_q <= 1'b1;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_n_s) begin
                  state_q   <= IDLE;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b0;
               end else if (sample_edge) begin
                  rx_shift_q <= rx_shift_d;
                  if (last_bit) begin
                     rx_data_q  <= rx_shift_d;
                     rx_valid_q <= 1'b1;
                     cnt_q      <= '0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     cnt_q  <= cnt_q + CW'(1);
                     busy_q <= 1'b1;
                  end
               end else if (shift_edge) begin
                  tx_shift_q <= tx_shift_d;
                  miso_q     <= tx_shift_d[HEAD];
               end
            end
            default: state_q <= WAIT_DESEL;
         endcase
         if (load_evt) begin
            tx_shift_q <= tx_shift_d;
            miso_q     <= tx_shift_d[HEAD];
            underrun_q <= !tx_full_q;
            tx_full_q  <= 1'b0;
            done_q     <= 1'b0;
         end
         if (tx_accept) begin
            tx_buf_q  <= tx_data_i;
            tx_full_q <= 1'b1;
         end
      end
   end

   assign miso_o     = miso_q;
   assign miso_oe_o  = miso_oe_q;
   assign tx_ready_o = !tx_full_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign busy_o     = busy_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench: a mode-0 8-bit MSB-first target and a mode-3 16-bit
// LSB-first target driven by behavioural SPI masters.
module tb_spi_slave_mode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
   logic        miso0, misoOe0, txValid0 = 1'b0, txReady0;
   logic        rxValid0, busy0, underrun0;
   logic [7:0]  txData0 = '0, rxData0;

   logic        sclk3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;
   logic        miso3, misoOe3, txValid3 = 1'b0, txReady3;
   logic        rxValid3, busy3, underrun3;
   logic [15:0] txData3 = '0, rxData3;

   int total = 0, bad = 0;
   int rxCnt0 = 0, urCnt0 = 0, rxCnt3 = 0, urCnt3 = 0, urMid0 = 0;

   always #5 clk = ~clk;

   spi_slave_mode d0 (
      .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk0), .spi_cs_n_i(cs0),
      .mosi_i(mosi0), .miso_o(miso0), .miso_oe_o(misoOe0),
      .tx_data_i(txData0), .tx_valid_i(txValid0), .tx_ready_o(txReady0),
      .rx_data_o(rxData0), .rx_valid_o(rxValid0), .busy_o(busy0),
      .underrun_o(underrun0)
   );

   spi_slave_mode #(
      .WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
   ) d3 (
      .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk3), .spi_cs_n_i(cs3),
      .mosi_i(mosi3), .miso_o(miso3), .miso_oe_o(misoOe3),
      .tx_data_i(txData3), .tx_valid_i(txValid3), .tx_ready_o(txReady3),
      .rx_data_o(rxData3), .rx_valid_o(rxValid3), .busy_o(busy3),
      .underrun_o(underrun3)
   );

   // Strobe counters: a strobe held for two cycles shows up as a count of two.
   always @(negedge clk) begin
      if (rxValid0)  rxCnt0++;
      if (underrun0) urCnt0++;
      if (rxValid3)  rxCnt3++;
      if (underrun3) urCnt3++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Mode-0 master: mosi set while sclk low, miso captured on the rising edge.
   task automatic applyStimulus0(input logic [7:0] txw, input int nbits,
                                 output logic [7:0] rxw);
      rxw = '0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi0 = txw[i];
         #80;
         sclk0 = 1'b1;
         rxw[i] = miso0;
         if (i == 0) urMid0 = urCnt0;
         #80;
         sclk0 = 1'b0;
      end
   endtask

   // Mode-3 LSB-first master: mosi driven on the falling edge, miso captured on rising.
   task automatic applyStimulus3(input logic [15:0] txw, output logic [15:0] rxw);
      rxw = '0;
      for (int i = 0; i < 16; i++) begin
         sclk3 = 1'b0;
         mosi3 = txw[i];
         #80;
         sclk3 = 1'b1;
         rxw[i] = miso3;
         #80;
      end
   endtask

   task automatic pushTx0(input logic [7:0] d);
      @(negedge clk);
      txData0  = d;
      txValid0 = 1'b1;
      @(negedge clk);
      txValid0 = 1'b0;
   endtask

   task automatic pushTx3(input logic [15:0] d);
      @(negedge clk);
      txData3  = d;
      txValid3 = 1'b1;
      @(negedge clk);
      txValid3 = 1'b0;
   endtask

   initial begin
      logic [7:0]  w0, w1;
      logic [15:0] w3;
      int          rxB, urB;

      repeat (5) @(negedge clk);
      checkOutput("rst_miso",     32'(miso0),     32'd0);
      checkOutput("rst_miso_oe",  32'(misoOe0),   32'd0);
      checkOutput("rst_tx_ready", 32'(txReady0),  32'd1);
      checkOutput("rst_rx_data",  32'(rxData0),   32'd0);
      checkOutput("rst_rx_valid", 32'(rxValid0),  32'd0);
      checkOutput("rst_busy",     32'(busy0),     32'd0);
      checkOutput("rst_underrun", 32'(underrun0), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Single mode-0 word with a buffered TX word
      urB = urCnt0;
      rxB = rxCnt0;
      pushTx0(8'hA5);
      checkOutput("m0_tx_ready_full", 32'(txReady0), 32'd0);
      cs0 = 1'b0;
      applyStimulus0(8'h3C, 8, w0);
      #60;
      checkOutput("m0_miso_word",   32'(w0),            32'hA5);
      checkOutput("m0_rx_data",     32'(rxData0),       32'h3C);
      checkOutput("m0_rx_pulses",   32'(rxCnt0 - rxB),  32'd1);
      checkOutput("m0_no_underrun", 32'(urMid0 - urB),  32'd0);
      checkOutput("m0_miso_oe_sel", 32'(misoOe0),       32'd1);
      cs0 = 1'b1;
      #100;
      checkOutput("m0_miso_oe_desel", 32'(misoOe0), 32'd0);
      checkOutput("m0_miso_desel",    32'(miso0),   32'd0);
      #100;

      // Back-to-back words, second TX word pushed mid-word
      rxB = rxCnt0;
      pushTx0(8'h11);
      cs0 = 1'b0;
      fork
         applyStimulus0(8'h5A, 8, w0);
         begin
            #600;
            pushTx0(8'h22);
            checkOutput("b2b_tx_ready_mid", 32'(txReady0), 32'd0);
         end
      join
      #40;
      checkOutput("b2b_tx_ready_after_load", 32'(txReady0), 32'd1);
      checkOutput("b2b_rx_data1", 32'(rxData0), 32'h5A);
      applyStimulus0(8'hC3, 8, w1);
      #60;
      checkOutput("b2b_miso1",     32'(w0),           32'h11);
      checkOutput("b2b_miso2",     32'(w1),           32'h22);
      checkOutput("b2b_rx_pulses", 32'(rxCnt0 - rxB), 32'd2);
      checkOutput("b2b_rx_data2",  32'(rxData0),      32'hC3);
      cs0 = 1'b1;
      #200;

      // Empty buffer at select
      urB = urCnt0;
      cs0 = 1'b0;
      #60;
      checkOutput("ur_pulse", 32'(urCnt0 - urB), 32'd1);
      applyStimulus0(8'h00, 8, w0);
      checkOutput("ur_fill_word", 32'(w0), 32'hFF);
      cs0 = 1'b1;
      #200;

      // Deselect after five bits
      rxB = rxCnt0;
      cs0 = 1'b0;
      applyStimulus0(8'hF0, 5, w0);
      #40;
      checkOutput("part_busy_mid", 32'(busy0), 32'd1);
      cs0 = 1'b1;
      #100;
      checkOutput("part_busy_after",  32'(busy0),        32'd0);
      checkOutput("part_no_rx_valid", 32'(rxCnt0 - rxB), 32'd0);
      cs0 = 1'b0;
      applyStimulus0(8'h96, 8, w0);
      #60;
      checkOutput("part_next_rx_data", 32'(rxData0),      32'h96);
      checkOutput("part_next_pulses",  32'(rxCnt0 - rxB), 32'd1);
      cs0 = 1'b1;
      #200;

      // Mode 3, 16-bit LSB first
      rxB = rxCnt3;
      urB = urCnt3;
      pushTx3(16'h1234);
      cs3 = 1'b0;
      #100;
      applyStimulus3(16'hBEEF, w3);
      #60;
      checkOutput("m3_miso_word",   32'(w3),           32'h1234);
      checkOutput("m3_rx_data",     32'(rxData3),      32'hBEEF);
      checkOutput("m3_rx_pulses",   32'(rxCnt3 - rxB), 32'd1);
      checkOutput("m3_no_underrun", 32'(urCnt3 - urB), 32'd0);
      cs3 = 1'b1;
      #200;

      // Reset mid-word with cs held low
      cs0 = 1'b0;
      #100;
      applyStimulus0(8'hAA, 3, w0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("mrst_miso",     32'(miso0),    32'd0);
      checkOutput("mrst_miso_oe",  32'(misoOe0),  32'd0);
      checkOutput("mrst_busy",     32'(busy0),    32'd0);
      checkOutput("mrst_rx_data",  32'(rxData0),  32'd0);
      checkOutput("mrst_tx_ready", 32'(txReady0), 32'd1);
      checkOutput("mrst_rx_valid", 32'(rxValid0), 32'd0);
      rst = 1'b0;
      rxB = rxCnt0;
      applyStimulus0(8'h55, 8, w0);
      #60;
      checkOutput("mrst_ignored_rx", 32'(rxCnt0 - rxB), 32'd0);
      checkOutput("mrst_ignored_oe", 32'(misoOe0),      32'd0);
      cs0 = 1'b1;
      #200;
      cs0 = 1'b0;
      applyStimulus0(8'h69, 8, w0);
      #60;
      checkOutput("mrst_next_rx_data", 32'(rxData0),      32'h69);
      checkOutput("mrst_next_pulses",  32'(rxCnt0 - rxB), 32'd1);
      checkOutput("mrst_next_miso",    32'(w0),           32'hFF);
      cs0 = 1'b1;
      #100;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_mode.md
Name: spi_slave_mode

Overview:
Parametrised SPI target, successor to the fixed 8-bit mode-0 slave. It oversamples spi_clk, spi_cs_n and mosi in the system clock domain and supports all four CPOL/CPHA modes, any word width and either bit order. Framing uses chip select. TX words are supplied through a valid/ready buffer, and RX words are delivered as single-cycle strobes. It sits between the SNES-side cart logic and an external SPI master (MCU/flash bridge).

Parameters:
WIDTH, 8, bits per word (2..32)
CPOL, 0, idle level of spi_clk
CPHA, 0, 0 = sample on leading edge / 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_cs_n/mosi (>=2)
IDLE_FILL, all-ones, WIDTH-bit word sent when no TX word is buffered

Ports:
clk  in  1  system clock; must be >= 8x spi_clk
rst  in  1  synchronous, active-high reset
spi_clk  in  1  async SPI clock from master
spi_cs_n  in  1  async chip select, active low
mosi  in  1  async master-out data
miso  out  1  target-out data
miso_oe  out  1  high while selected (synced cs_n low); external tristate enable
tx_data  in  WIDTH  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX buffer empty; transfer occurs when tx_valid && tx_ready
rx_data  out  WIDTH  last completed received word, held until next completion
rx_valid  out  1  one-cycle strobe, rx_data updated this cycle
busy  out  1  word in progress (>=1 bit sampled, word not complete)
underrun  out  1  one-cycle strobe: word started with TX buffer empty (IDLE_FILL sent)

Behaviour:
- Reset:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0.
  - Bit counter=0, TX buffer empty, state=WAIT_DESEL.
- Sync: each async input passes SYNC_STAGES flops.
- Edges: detected by comparing the last two synced spi_clk values.
  - leading = transition away from CPOL; trailing = transition back to CPOL.
  - sample edge = leading if CPHA=0, else trailing; shift edge = the other edge.
- TX buffer: one WIDTH-bit register. It is filled on tx_valid&&tx_ready, and tx_ready drops the next cycle. The buffer empties when its contents are loaded into the shift register.
- Word load: the shift register loads from the buffer, or IDLE_FILL if the buffer is empty (underrun strobes the same cycle). Load points:
  - CPHA=0: synced cs_n falling, and the shift edge following each completed word while still selected.
  - CPHA=1: first leading edge of each word.
- miso:
  - Driven from the head bit of the shift register (MSB or LSB per MSB_FIRST).
  - Advances one bit on each shift edge, except the edge that performs a load.
  - Holds the head bit of the loaded word after a load.
  - 0 while deselected.
- RX:
  - Each sample edge shifts synced mosi into the RX shift register and increments the bit counter.
  - On sample WIDTH (counter==WIDTH-1), the cycle after edge detect: rx_data <= assembled word, rx_valid=1 for exactly one cycle, counter wraps to 0, busy=0.
  - Bit order matches MSB_FIRST.
- States:
  - WAIT_DESEL (synced cs_n low after reset: ignore all edges) -> IDLE when cs_n high.
  - IDLE -> ACTIVE on synced cs_n low.
  - ACTIVE -> IDLE on synced cs_n high.
- Deselect mid-word: partial word discarded, no rx_valid, counter=0. A TX word already loaded is consumed, not restored to the buffer.
- Back-to-back words with cs_n held low are supported with no gap. A new tx_valid may be accepted any cycle the buffer is empty, including mid-word.
- Simultaneous events:
  - TX buffer fill and load in the same cycle: the load takes the old contents (empty means IDLE_FILL), and the new word goes into the buffer.
  - rst has priority over everything.
- Latency: mosi pin to rx_data is <= SYNC_STAGES+2 clk after the final sample edge at the pin.

Decomposition:
- Package spi_pkg: state enum (WAIT_DESEL, IDLE, ACTIVE); mode constants MODE0..MODE3 as {CPOL,CPHA}; helper function for the head-bit index from WIDTH/MSB_FIRST.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser for the three inputs plus leading/trailing edge strobes. Instantiated once.

Test Plan:
- Mode 0, WIDTH=8, MSB first; TX 0xA5 buffered; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse; underrun=0.
- Mode 3, WIDTH=16, LSB first; TX 0x1234; master sends 0xBEEF -> miso LSB-first 0x1234; rx_data=0xBEEF.
- Two back-to-back 8-bit words, cs held low; TX 0x11 buffered, 0x22 pushed mid-first-word -> miso 0x11 then 0x22; two rx_valid pulses; tx_ready high again after second load.
- Empty TX buffer at cs fall -> underrun one-cycle pulse; miso sends 0xFF.
- cs_n deasserted after 5 bits -> no rx_valid, busy=0; next full word received correctly from bit 0.
- rst asserted mid-word with cs low -> outputs at reset values; edges ignored until cs_n high; then next frame is received correctly.
